rr_mux_arbiter: RTL
===================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 128, width of each requester data word.
REQ-002 SHALL have parameter NUM_REQ, default 16, fixed at 16; other values are out of scope.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_valid  input  16  requester i has a beat pending.
REQ-006 SHALL have port req_last  input  16  requester i's current beat ends its packet.
REQ-007 SHALL have port req_data  input  [0:15][DATA_W-1:0] packed  per-requester data; entry i = requester i.
REQ-008 SHALL have port req_ready  output  16  one-hot-or-zero; beat i accepted when req_valid[i] & req_ready[i].
REQ-009 SHALL have port out_valid  output  1  out_data holds a beat.
REQ-010 SHALL have port out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-011 SHALL have port out_data  output  DATA_W  registered selected beat.
REQ-012 SHALL have port out_src  output  4  requester index of out_data.
REQ-013 SHALL have port out_last  output  1  registered copy of accepted req_last.

Function
REQ-014 SHALL hold a 4-bit round-robin pointer last_grant; search order is last_grant+1, +2, ... wrapping 15->0.
REQ-015 SHALL have FSM states ARB and HOLD.
REQ-016 SHALL define slot_free = ~out_valid | out_ready.
REQ-017 SHALL in ARB with slot_free assert req_ready only for the first requester in search order with req_valid=1; none if req_valid==0.
REQ-018 SHALL in HOLD with slot_free assert req_ready only for requester last_grant, regardless of its req_valid.
REQ-019 SHALL assert req_ready==0 whenever slot_free==0.
REQ-020 SHALL, on acceptance of requester w, load out_data=req_data[w], out_src=w, out_last=req_last[w], out_valid=1 at the next edge (latency 1 cycle).
REQ-021 SHALL on acceptance in ARB set last_grant=w, then go to HOLD if req_last[w]==0, else stay in ARB.
REQ-022 SHALL on acceptance in HOLD go to ARB if req_last==1, else stay in HOLD; last_grant unchanged.
REQ-023 SHALL in HOLD wait indefinitely if the held requester drops req_valid; no other requester granted.
REQ-024 SHALL clear out_valid when out_ready=1 and no new beat is accepted the same cycle.
REQ-025 SHALL sustain one beat per cycle when out_ready is held 1 (simultaneous unload and load).
REQ-026 SHALL keep last_grant and state unchanged when nothing is accepted.
REQ-027 SHALL keep out_data/out_src/out_last stable while out_valid=1 and out_ready=0.

Reset
REQ-028 SHALL on rst: state=ARB, last_grant=15 (requester 0 first), out_valid=0, out_data=0, out_src=0, out_last=0.
REQ-029 SHALL abandon any packet in progress on rst mid-HOLD; no beat resumes after reset.
REQ-030 SHALL drive req_ready=0 while rst is asserted.

Structure
REQ-031 SHALL take NUM_REQ, index width (4) and the ARB/HOLD state enum from shared package mux_pkg.
REQ-032 SHALL instantiate the team's existing mux_16 as the single sub-module for data selection, select driven by the encoded winner index.
REQ-033 SHALL implement the priority search as a rotate/priority-encode, no per-cycle loop state beyond last_grant.

Verification
REQ-034 After reset, req_valid=16'hFFFF, all req_last=1, out_ready=1, req_data[j]=0xabcd_0000+j -> out_src 0,1,...,15,0 on consecutive cycles, out_data matches.
REQ-035 req_valid=16'h8001 only, req_last=1, out_ready=1 -> grants alternate 0,15,0,15 (wrap verified).
REQ-036 Requester 3 sends 4-beat packet (last on beat 4) while req_valid=16'hFFFF -> four consecutive out_src=3 beats, next grant is 4.
REQ-037 out_valid=1, out_ready=0 for 5 cycles -> req_ready=0, out_data unchanged; out_ready=1 -> next beat loads same cycle.
REQ-038 Requester 5 in HOLD drops req_valid 3 cycles while 6 requests -> no grant to 6 until 5 delivers last beat.
REQ-039 rst asserted mid-packet of requester 7 -> outputs per REQ-028 immediately; after release requester 0 served first.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared constants, arbiter state type and the round-robin winner search
// used by the 16-way packet-aware multiplexer.
package mux_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    HOLD = 1'b1
  } arb_state_e;

  // Rotate the request vector so that ptr+1 lands at bit 0, then take the lowest set bit.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [2*NUM_REQ-1:0] dbl;
    logic [NUM_REQ-1:0]   rot;
    logic [IDX_W-1:0]     start;
    logic [IDX_W-1:0]     off;
    start = ptr + 1'b1;
    dbl   = {req, req} >> start;
    rot   = dbl[NUM_REQ-1:0];
    off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IDX_W-1:0];
    end
    return start + off;
  endfunction

endpackage

// File: rtl/mux_16.sv
// Plain 16:1 data selector; entry i of din is returned when sel == i.
module mux_16 #(
  parameter int DATA_W = 128
) (
  input  logic [0:15][DATA_W-1:0] din,
  input  logic [3:0]              sel,
  output logic [DATA_W-1:0]       dout
);

  assign dout = din[sel];

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin 16:1 packet multiplexer: packets are never interleaved, and the
// selected beat is held in a single output register with ready/valid flow control.
module rr_mux_arbiter
  import mux_pkg::*;
#(
  parameter int DATA_W  = 128,
  parameter int NUM_REQ = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_last,
  input  logic [0:NUM_REQ-1][DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_W-1:0]               out_data,
  output logic [IDX_W-1:0]                out_src,
  output logic                            out_last
);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [IDX_W-1:0]   out_src_q, out_src_d;
  logic               out_last_q, out_last_d;

  logic               slot_free;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_en;
  logic               accept;
  logic [DATA_W-1:0]  sel_data;

  // In HOLD the held requester owns the slot even while its valid is low.
  always_comb begin
    slot_free = ~out_valid_q | out_ready;
    win_idx   = rr_pick(req_valid, last_grant_q);
    grant_idx = (state_q == HOLD) ? last_grant_q : win_idx;
    grant_en  = ~rst & slot_free & ((state_q == HOLD) | (|req_valid));
    req_ready = grant_en ? (NUM_REQ'(1) << grant_idx) : '0;
    accept    = grant_en & req_valid[grant_idx];
  end

  mux_16 #(
    .DATA_W (DATA_W)
  ) u_mux (
    .din  (req_data),
    .sel  (grant_idx),
    .dout (sel_data)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
    out_last_d   = out_last_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_src_d   = grant_idx;
      out_last_d  = req_last[grant_idx];
      if (state_q == ARB) last_grant_d = win_idx;
      state_d = req_last[grant_idx] ? ARB : HOLD;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_src_q    <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
      out_last_q   <= out_last_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;

endmodule
